ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder_pkg.sv | 14 +
 rtl/ps2_key_decoder_if.sv | 32 +++
 rtl/ps2_key_decoder_frame_rx.sv | 129 ++++++++++++
 rtl/ps2_key_decoder.sv | 104 ++++++++++
 tb/tb_ps2_key_decoder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and frame FSM encoding for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin pair plus the decoded display/debug outputs.
interface ps2_key_decoder_if;

    logic       ps2_clk;
    logic       ps2_dat;
    logic       letter;
    logic       display;
    logic [7:0] scan_code;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_dat,
        input  letter,
        input  display,
        input  scan_code,
        input  byte_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output letter,
        output display,
        output scan_code,
        output byte_valid,
        output frame_err
    );

endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, frame FSM.
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       rx_good,
    output logic       rx_err,
    output logic [7:0] rx_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          dat;

    frame_state_t  state_q;
    frame_state_t  state_d;
    logic [7:0]    shreg_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TW-1:0] timer_q;

    logic          start;
    logic          shift;
    logic          cap_par;
    logic          done;
    logic          timeout;

    // Sync flops idle high so reset never fakes a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];

    assign timeout = (state_q != IDLE) && !fall
                   && (timer_q == T_MAX);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        shift   = 1'b0;
        cap_par = 1'b0;
        done    = 1'b0;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        start   = 1'b1;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    shift = 1'b1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    cap_par = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data = shreg_q;
    assign rx_good = done & dat & (^{shreg_q, par_q});
    assign rx_err  = done & ~rx_good;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            scan_code  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_valid <= rx_good;
            frame_err  <= rx_err;
            if (fall || state_q == IDLE)
                timer_q <= '0;
            else
                timer_q <= timer_q + 1'b1;
            if (start)
                bit_cnt_q <= 3'd0;
            if (shift) begin
                shreg_q   <= {dat, shreg_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (cap_par)
                par_q <= dat;
            if (rx_good)
                scan_code <= shreg_q;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 scan codes into the letter/display pair for two keys.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  KEY0_CODE      = 8'h23,
    parameter logic [7:0]  KEY1_CODE      = 8'h4B
) (
    input  logic        clock,
    input  logic        reset,
    ps2_key_decoder_if.slave bus
);

    logic       rx_good;
    logic       rx_err;
    logic [7:0] rx_data;

    logic held0_q, held0_d;
    logic held1_q, held1_d;
    logic brk_q, brk_d;
    logic ext_q, ext_d;
    logic letter_q, letter_d;
    logic display_q;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_dat    (bus.ps2_dat),
        .scan_code  (bus.scan_code),
        .byte_valid (bus.byte_valid),
        .frame_err  (bus.frame_err),
        .rx_good    (rx_good),
        .rx_err     (rx_err),
        .rx_data    (rx_data)
    );

    // Acts on the unregistered byte so outputs move with byte_valid.
    always_comb begin
        held0_d  = held0_q;
        held1_d  = held1_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        letter_d = letter_q;
        if (rx_err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_good) begin
            unique case (1'b1)
                (rx_data == PS2_EXT):   ext_d = 1'b1;
                (rx_data == PS2_BREAK): brk_d = 1'b1;
                default: begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                    if (!ext_q && !brk_q) begin
                        if (rx_data == KEY0_CODE && !held0_q) begin
                            held0_d  = 1'b1;
                            letter_d = 1'b0;
                        end
                        if (rx_data == KEY1_CODE && !held1_q) begin
                            held1_d  = 1'b1;
                            letter_d = 1'b1;
                        end
                    end else if (!ext_q) begin
                        if (rx_data == KEY0_CODE && held0_q) begin
                            held0_d = 1'b0;
                            if (held1_q)
                                letter_d = 1'b1;
                        end
                        if (rx_data == KEY1_CODE && held1_q) begin
                            held1_d = 1'b0;
                            if (held0_q)
                                letter_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held0_q   <= 1'b0;
            held1_q   <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            letter_q  <= 1'b0;
            display_q <= 1'b0;
        end else begin
            held0_q   <= held0_d;
            held1_q   <= held1_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            letter_q  <= letter_d;
            display_q <= held0_d | held1_d;
        end
    end

    assign bus.letter  = letter_q;
    assign bus.display = display_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a scaled PS/2 clock.
module tb_ps2_key_decoder;

    localparam int TO   = 200;
    localparam int HALF = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TO),
        .KEY0_CODE     (8'h23),
        .KEY1_CODE     (8'h4B)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int vcnt = 0;
    int ecnt = 0;
    int lat = 0;
    int v0, e0;

    always @(negedge clock) begin
        if (bus.byte_valid) vcnt++;
        if (bus.frame_err) ecnt++;
    end

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        bus.ps2_dat = b;
        repeat (HALF) @(negedge clock);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip);
        logic [9:0] f;
        f = {(~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clock);
        bus.ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        bus.ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (lat == 0 && (bus.byte_valid || bus.frame_err))
                lat = i;
        end
        repeat (HALF - 6) @(negedge clock);
        bus.ps2_clk = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_letter", 8'(bus.letter), 8'd0);
        chk("rst_display", 8'(bus.display), 8'd0);
        chk("rst_scan", bus.scan_code, 8'h00);
        chk("rst_valid", 8'(bus.byte_valid), 8'd0);
        chk("rst_err", 8'(bus.frame_err), 8'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        v0 = vcnt;
        send_frame(8'h23, 1'b0);
        chk("m23_lat_ok", 8'(lat >= 1 && lat <= 4), 8'd1);
        chk("m23_pulses", 8'(vcnt - v0), 8'd1);
        chk("m23_scan", bus.scan_code, 8'h23);
        chk("m23_letter", 8'(bus.letter), 8'd0);
        chk("m23_display", 8'(bus.display), 8'd1);

        send_frame(8'h4B, 1'b0);
        chk("m4b_letter", 8'(bus.letter), 8'd1);
        chk("m4b_display", 8'(bus.display), 8'd1);

        send_frame(8'h4B, 1'b0);
        chk("rep4b_letter", 8'(bus.letter), 8'd1);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h4B, 1'b0);
        chk("b4b_letter", 8'(bus.letter), 8'd0);
        chk("b4b_display", 8'(bus.display), 8'd1);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        chk("b23_letter", 8'(bus.letter), 8'd0);
        chk("b23_display", 8'(bus.display), 8'd0);

        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h23, 1'b1);
        chk("perr_lat_ok", 8'(lat >= 1 && lat <= 4), 8'd1);
        chk("perr_err", 8'(ecnt - e0), 8'd1);
        chk("perr_valid", 8'(vcnt - v0), 8'd0);
        chk("perr_scan", bus.scan_code, 8'h23);
        chk("perr_display", 8'(bus.display), 8'd0);

        v0 = vcnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h23, 1'b0);
        chk("ext_pulses", 8'(vcnt - v0), 8'd2);
        chk("ext_display", 8'(bus.display), 8'd0);
        send_frame(8'h23, 1'b0);
        chk("post_ext_display", 8'(bus.display), 8'd1);
        chk("post_ext_letter", 8'(bus.letter), 8'd0);

        v0 = vcnt;
        e0 = ecnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO) @(negedge clock);
        chk("to_valid", 8'(vcnt - v0), 8'd0);
        chk("to_err", 8'(ecnt - e0), 8'd0);
        send_frame(8'h4B, 1'b0);
        chk("to_scan", bus.scan_code, 8'h4B);
        chk("to_letter", 8'(bus.letter), 8'd1);
        chk("to_pulses", 8'(vcnt - v0), 8'd1);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mrst_letter", 8'(bus.letter), 8'd0);
        chk("mrst_display", 8'(bus.display), 8'd0);
        chk("mrst_scan", bus.scan_code, 8'h00);
        chk("mrst_valid", 8'(bus.byte_valid), 8'd0);
        chk("mrst_err", 8'(bus.frame_err), 8'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        v0 = vcnt;
        send_frame(8'h23, 1'b0);
        chk("after_rst_scan", bus.scan_code, 8'h23);
        chk("after_rst_display", 8'(bus.display), 8'd1);
        chk("after_rst_letter", 8'(bus.letter), 8'd0);
        chk("after_rst_pulses", 8'(vcnt - v0), 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
